// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    DATA0 = 3'd0,
    DATA1 = 3'd1,
    ACK   = 3'd2,
    NAK   = 3'd3,
    STALL = 3'd4
  } tx_pkt_t;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  typedef enum logic [3:0] {
    StIdle,
    StLatch,
    StSync,
    StPid,
    StData,
    StCrcLo,
    StCrcHi,
    StEop,
    StDone
  } tx_state_t;

  function automatic logic [3:0] pid_of(input tx_pkt_t pkt);
    logic [3:0] pid;
    case (pkt)
      DATA0:   pid = PID_DATA0;
      DATA1:   pid = PID_DATA1;
      ACK:     pid = PID_ACK;
      NAK:     pid = PID_NAK;
      default: pid = PID_STALL;
    endcase
    return pid;
  endfunction

  function automatic logic is_data(input tx_pkt_t pkt);
    return (pkt == DATA0) || (pkt == DATA1);
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_crc16_byte.sv
// Combinational CRC16 (reflected 0x8005) advance over one byte, LSB first.
module crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Eight serial LFSR steps unrolled.
  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC16_POLY_R;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// Packet-level TX controller: drives the bit/byte timer, selects SYNC/PID/data/CRC bytes for the
// shift register, pops the TX FIFO and runs EOP.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int unsigned MAX_PKT  = 64,
  parameter int unsigned EOP_BITS = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  tx_pkt_t    tx_packet,
  input  logic [6:0] tx_packet_size,
  input  logic       bit_tick,
  input  logic       byte_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_pop,
  output logic       timer_clear,
  output logic       timer_count_en,
  output logic       timer_latch_size,
  output logic       load_byte,
  output logic [7:0] tx_byte,
  output logic       eop_active,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [7:0] MaxPktB = 8'(MAX_PKT);
  localparam logic [7:0] EopLast = 8'(EOP_BITS - 1);

  tx_state_t   state_q;
  tx_pkt_t     pkt_q;
  logic [6:0]  size_q;
  logic [6:0]  count_q;
  logic [15:0] crc_q;
  logic [15:0] crc_next;
  logic [7:0]  eop_cnt_q;
  logic        bit_q;
  logic        byte_q;
  logic        bit_edge;
  logic        byte_edge;
  logic [3:0]  pid;

  crc16_byte u_crc16_byte (
    .crc_in  (crc_q),
    .data    (fifo_rdata),
    .crc_out (crc_next)
  );

  // Ticks may be stretched by the timer; only rising edges advance the sequence.
  assign bit_edge  = bit_tick & ~bit_q;
  assign byte_edge = byte_tick & ~byte_q;
  assign pid       = pid_of(pkt_q);

  // Tick delay registers, held low in IDLE so a stale level cannot fake an edge on start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_q  <= 1'b0;
      byte_q <= 1'b0;
    end else if (state_q == StIdle) begin
      bit_q  <= 1'b0;
      byte_q <= 1'b0;
    end else begin
      bit_q  <= bit_tick;
      byte_q <= byte_tick;
    end
  end

  // Packet FSM with registered strobes, timer controls and byte selection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= StIdle;
      pkt_q            <= DATA0;
      size_q           <= '0;
      count_q          <= '0;
      crc_q            <= CRC16_INIT;
      eop_cnt_q        <= '0;
      fifo_pop         <= 1'b0;
      timer_clear      <= 1'b0;
      timer_count_en   <= 1'b0;
      timer_latch_size <= 1'b0;
      load_byte        <= 1'b0;
      tx_byte          <= '0;
      eop_active       <= 1'b0;
      tx_busy          <= 1'b0;
      tx_done          <= 1'b0;
      tx_error         <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      fifo_pop         <= 1'b0;
      load_byte        <= 1'b0;
      timer_latch_size <= 1'b0;
      tx_done          <= 1'b0;
      tx_error         <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (tx_start) begin
            if (is_data(tx_packet) && ({1'b0, tx_packet_size} > MaxPktB)) begin
              tx_error <= 1'b1;
            end else begin
              state_q          <= StLatch;
              pkt_q            <= tx_packet;
              size_q           <= tx_packet_size;
              crc_q            <= CRC16_INIT;
              count_q          <= '0;
              timer_clear      <= 1'b1;
              timer_latch_size <= 1'b1;
              tx_busy          <= 1'b1;
            end
          end
        end

        StLatch: begin
          state_q        <= StSync;
          timer_clear    <= 1'b0;
          timer_count_en <= 1'b1;
          load_byte      <= 1'b1;
          tx_byte        <= SYNC_BYTE;
        end

        StSync: begin
          if (byte_edge) begin
            state_q   <= StPid;
            load_byte <= 1'b1;
            tx_byte   <= {~pid, pid};
          end
        end

        StPid: begin
          if (byte_edge) begin
            if (!is_data(pkt_q)) begin
              state_q    <= StEop;
              eop_active <= 1'b1;
              eop_cnt_q  <= '0;
            end else if (size_q == '0) begin
              state_q   <= StCrcLo;
              load_byte <= 1'b1;
              tx_byte   <= ~crc_q[7:0];
            end else if (fifo_empty) begin
              // Underrun on the very first payload byte: abort straight to EOP.
              state_q    <= StEop;
              eop_active <= 1'b1;
              eop_cnt_q  <= '0;
              tx_error   <= 1'b1;
            end else begin
              state_q   <= StData;
              load_byte <= 1'b1;
              tx_byte   <= fifo_rdata;
              fifo_pop  <= 1'b1;
              crc_q     <= crc_next;
              count_q   <= count_q + 7'd1;
            end
          end
        end

        StData: begin
          if (byte_edge) begin
            if (count_q == size_q) begin
              state_q   <= StCrcLo;
              load_byte <= 1'b1;
              tx_byte   <= ~crc_q[7:0];
            end else if (fifo_empty) begin
              // Underrun mid-payload: no CRC is sent, the packet is cut with EOP.
              state_q    <= StEop;
              eop_active <= 1'b1;
              eop_cnt_q  <= '0;
              tx_error   <= 1'b1;
            end else begin
              load_byte <= 1'b1;
              tx_byte   <= fifo_rdata;
              fifo_pop  <= 1'b1;
              crc_q     <= crc_next;
              count_q   <= count_q + 7'd1;
            end
          end
        end

        StCrcLo: begin
          if (byte_edge) begin
            state_q   <= StCrcHi;
            load_byte <= 1'b1;
            tx_byte   <= ~crc_q[15:8];
          end
        end

        StCrcHi: begin
          if (byte_edge) begin
            state_q    <= StEop;
            eop_active <= 1'b1;
            eop_cnt_q  <= '0;
          end
        end

        StEop: begin
          if (bit_edge) begin
            if (eop_cnt_q == EopLast) begin
              state_q        <= StDone;
              eop_active     <= 1'b0;
              tx_done        <= 1'b1;
              timer_count_en <= 1'b0;
              timer_clear    <= 1'b1;
            end else begin
              eop_cnt_q <= eop_cnt_q + 8'd1;
            end
          end
        end

        StDone: begin
          state_q     <= StIdle;
          timer_clear <= 1'b0;
          tx_busy     <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: bench-side timer and FIFO models, a packet-level
// reference model, a directed vector table, hand sequences and randomized packets.
module tb_usb_tx_sequencer;
  import usb_tx_pkg::*;

  localparam int MaxPkt  = 64;
  localparam int EopBits = 3;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  tx_pkt_t    tx_packet = ACK;
  logic [6:0] tx_packet_size = '0;
  logic       bit_tick = 1'b0;
  logic       byte_tick = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = '0;
  logic       fifo_pop, timer_clear, timer_count_en, timer_latch_size, load_byte;
  logic [7:0] tx_byte;
  logic       eop_active, tx_busy, tx_done, tx_error;

  usb_tx_sequencer #(
    .MAX_PKT  (MaxPkt),
    .EOP_BITS (EopBits)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .tx_start         (tx_start),
    .tx_packet        (tx_packet),
    .tx_packet_size   (tx_packet_size),
    .bit_tick         (bit_tick),
    .byte_tick        (byte_tick),
    .fifo_empty       (fifo_empty),
    .fifo_rdata       (fifo_rdata),
    .fifo_pop         (fifo_pop),
    .timer_clear      (timer_clear),
    .timer_count_en   (timer_count_en),
    .timer_latch_size (timer_latch_size),
    .load_byte        (load_byte),
    .tx_byte          (tx_byte),
    .eop_active       (eop_active),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .tx_error         (tx_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Environment knobs and monitor state.
  int         bit_len = 4;
  int         stretch = 1;
  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];
  int         cyc = 0;
  int         last_load = 0;
  bit         have_last = 0;
  int         pop_cnt = 0, pop_bad = 0, err_cnt = 0, done_cnt = 0, done_bad = 0;
  int         eop_len = 0, spacing_bad = 0;
  bit         prev_eop = 0;
  int         ph = 0, bc = 0, hold = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {fifo_pop, timer_clear, timer_count_en, timer_latch_size, load_byte, tx_byte,
            eop_active, tx_busy, tx_done, tx_error};
  endfunction

  function automatic logic [3:0] exp_pid(input tx_pkt_t p);
    case (p)
      DATA0:   return 4'b0011;
      DATA1:   return 4'b1011;
      ACK:     return 4'b0010;
      NAK:     return 4'b1010;
      default: return 4'b1110;
    endcase
  endfunction

  // Monitor, FWFT FIFO model and bit/byte timer model, all on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (load_byte) begin
      got_q.push_back(tx_byte);
      if (have_last && (cyc - last_load) != 8 * bit_len) spacing_bad++;
      last_load = cyc;
      have_last = 1;
    end
    if (fifo_pop) begin
      pop_cnt++;
      if (!load_byte || fifo_q.size() == 0) pop_bad++;
      else begin
        if (tx_byte != fifo_q[0]) pop_bad++;
        void'(fifo_q.pop_front());
      end
    end
    if (tx_error) err_cnt++;
    if (eop_active) eop_len++;
    if (tx_done) begin
      done_cnt++;
      if (!prev_eop || eop_active) done_bad++;
    end
    prev_eop   = eop_active;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
    if (timer_clear || !timer_count_en) begin
      ph = 0; bc = 0; hold = 0;
      bit_tick = 1'b0; byte_tick = 1'b0;
    end else begin
      ph++;
      if (ph == bit_len) begin
        ph        = 0;
        byte_tick = (bc == 7);
        bc        = (bc + 1) % 8;
        bit_tick  = 1'b1;
        hold      = stretch - 1;
      end else if (hold > 0) begin
        hold--;
      end else begin
        bit_tick  = 1'b0;
        byte_tick = 1'b0;
      end
    end
  end

  // Runs one packet and checks it against the packet-level model.
  task automatic run_packet(input tx_pkt_t pkt, input int size, input int fill, input int blen,
                            input int str, input bit seq, input bit mid);
    logic [7:0]  src[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic [15:0] crc;
    logic [3:0]  p;
    bit          fb;
    int          ndata;
    bit          under;
    int          budget;
    for (int i = 0; i < fill; i++) src.push_back(seq ? 8'(8'h31 + i) : 8'($urandom));
    @(negedge clk);
    bit_len = blen;
    stretch = str;
    fifo_q  = src;
    got_q.delete();
    pop_cnt = 0; pop_bad = 0; err_cnt = 0; done_cnt = 0; done_bad = 0;
    eop_len = 0; spacing_bad = 0; have_last = 0;
    @(negedge clk);
    tx_packet      = pkt;
    tx_packet_size = 7'(size);
    tx_start       = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("latch_strobes", {timer_clear, timer_latch_size, tx_busy, timer_count_en}, 4'b1110);
    budget = (size + 8) * 8 * blen + 64;
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      @(negedge clk);
      if (mid && c == 20) begin
        tx_start       = 1'b1;
        tx_packet      = DATA0;
        tx_packet_size = 7'd2;
      end else begin
        tx_start = 1'b0;
      end
    end
    tx_start = 1'b0;
    repeat (3) @(negedge clk);

    exp_q.push_back(8'h80);
    p = exp_pid(pkt);
    exp_q.push_back({~p, p});
    ndata = 0;
    under = 0;
    if (pkt == DATA0 || pkt == DATA1) begin
      crc   = 16'hFFFF;
      under = (fill < size);
      ndata = under ? fill : size;
      for (int i = 0; i < ndata; i++) begin
        b = src[i];
        exp_q.push_back(b);
        for (int k = 0; k < 8; k++) begin
          fb  = crc[0] ^ b[k];
          crc = crc >> 1;
          if (fb) crc = crc ^ 16'hA001;
        end
      end
      if (!under) begin
        exp_q.push_back(~crc[7:0]);
        exp_q.push_back(~crc[15:8]);
      end
    end

    check("done_count", done_cnt, 1);
    check("done_after_eop", done_bad, 0);
    check("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    check("pop_count", pop_cnt, ndata);
    check("pop_with_load", pop_bad, 0);
    check("err_pulses", err_cnt, under ? 1 : 0);
    check("byte_spacing", spacing_bad, 0);
    check("eop_cycles", eop_len, EopBits * blen);
    check("idle_after", {tx_busy, timer_count_en, eop_active}, 3'b000);
  endtask

  typedef struct {
    tx_pkt_t    pkt;
    int         size;
    int         fill;
    int         blen;
    int         str;
    bit         mid;
    int         exp_n;
    int         exp_err;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{ACK,   0,   3, 4, 1, 1'b0, 2,  0, 8'hD2};
    vecs[1] = '{DATA0, 9,   9, 4, 1, 1'b0, 13, 0, 8'hB4};
    vecs[2] = '{DATA1, 0,   0, 3, 1, 1'b0, 4,  0, 8'h00};
    vecs[3] = '{DATA0, 4,   2, 3, 1, 1'b0, 4,  1, 8'h32};
    vecs[4] = '{NAK,   0,   0, 5, 3, 1'b0, 2,  0, 8'h5A};
    vecs[5] = '{STALL, 0,   0, 3, 2, 1'b0, 2,  0, 8'h1E};
    vecs[6] = '{DATA0, 9,   9, 5, 3, 1'b0, 13, 0, 8'hB4};
    vecs[7] = '{ACK,   100, 0, 4, 1, 1'b0, 2,  0, 8'hD2};
    vecs[8] = '{DATA1, 9,   9, 4, 1, 1'b1, 13, 0, 8'hB4};
    vecs[9] = '{DATA0, 4,   0, 3, 1, 1'b0, 2,  1, 8'hC3};

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 17'h0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_outs", all_outs(), 17'h0);

    for (int v = 0; v < 10; v++) begin
      run_packet(vecs[v].pkt, vecs[v].size, vecs[v].fill, vecs[v].blen, vecs[v].str, 1'b1,
                 vecs[v].mid);
      check($sformatf("vec%0d_nbytes", v), got_q.size(), vecs[v].exp_n);
      check($sformatf("vec%0d_err", v), err_cnt, vecs[v].exp_err);
      if (got_q.size() > 0)
        check($sformatf("vec%0d_last", v), got_q[got_q.size() - 1], vecs[v].exp_last);
    end

    // Oversize DATA requests are rejected with a single error pulse and no busy.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tx_packet      = (k == 0) ? DATA0 : DATA1;
      tx_packet_size = (k == 0) ? 7'd65 : 7'd127;
      tx_start       = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check("oversize_err", tx_error, 1'b1);
      check("oversize_busy", tx_busy, 1'b0);
      @(negedge clk);
      check("oversize_pulse", {tx_error, tx_busy, timer_clear}, 3'b000);
    end

    // Largest legal payload.
    run_packet(DATA0, MaxPkt, MaxPkt, 3, 1, 1'b0, 1'b0);

    // Reset asserted mid-payload clears everything at once and nothing resumes.
    begin
      int budget_left;
      int pops_at_rst;
      @(negedge clk);
      bit_len = 3;
      stretch = 1;
      fifo_q.delete();
      for (int i = 0; i < 9; i++) fifo_q.push_back(8'(8'h31 + i));
      pop_cnt = 0; done_cnt = 0;
      tx_packet      = DATA0;
      tx_packet_size = 7'd9;
      tx_start       = 1'b1;
      @(negedge clk);
      tx_start    = 1'b0;
      budget_left = 2000;
      while (pop_cnt < 3 && budget_left > 0) begin
        @(negedge clk);
        budget_left--;
      end
      check("rst_reached_data", pop_cnt >= 3, 1'b1);
      n_rst = 1'b0;
      #1;
      check("rst_async_outs", all_outs(), 17'h0);
      @(negedge clk);
      check("rst_hold_outs", all_outs(), 17'h0);
      pops_at_rst = pop_cnt;
      @(negedge clk);
      n_rst = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_no_pop", pop_cnt, pops_at_rst);
      check("rst_no_done", done_cnt, 0);
      check("rst_idle", tx_busy, 1'b0);
    end

    // Randomized packets against the reference model.
    for (int r = 0; r < 25; r++) begin
      tx_pkt_t pkt;
      int size, fill, blen, str;
      pkt  = tx_pkt_t'(3'($urandom_range(0, 4)));
      size = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MaxPkt))
                                         : int'($urandom_range(0, 10));
      fill = size;
      if (size > 0 && $urandom_range(0, 3) == 0) fill = int'($urandom_range(0, size - 1));
      blen = int'($urandom_range(3, 6));
      str  = int'($urandom_range(1, (blen - 1 > 3) ? 3 : blen - 1));
      run_packet(pkt, size, fill, blen, str, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
